ifetch: RTL

Instruction fetch stage for the s_proc_v1 core. It holds the program counter and issues word reads to instruction memory over a req/ack handshake. Each returned 16-bit word is presented, together with a one-cycle load strobe, to the instruction register directly downstream (`instr` → IR `d_in`, `en_ir` → IR `en_ir`). It accepts branch redirects from the control unit and stalls until the control unit requests the next instruction.

---
 rtl/ifetch.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage for s_proc_v1 -- holds the PC, reads instruction memory over req/ack,
// strobes each word into the IR and handles branch redirects. Define IFETCH_TIMEOUT_EN for the memory watchdog.
module ifetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       instr,
    output logic              en_ir,
    output logic [ADDR_W-1:0] pc,
    input  logic              next_req,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              mem_rd_q, mem_rd_d;
    logic              en_ir_q, en_ir_d;
    logic              pend_q, pend_d;
    logic [15:0]       instr_q, instr_d;

    logic              redir_any;
    logic [ADDR_W-1:0] redirect_addr;
    logic [ADDR_W-1:0] issue_addr;
    logic              timeout;

`ifdef IFETCH_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    // cnt_q counts no-ack fetch cycles already elapsed; this is the 255th one.
    assign timeout = (state_q == S_FETCH) && !mem_ack && (cnt_q == 8'd254);
`else
    assign timeout = 1'b0;
`endif

    // A same-cycle br_valid beats both the sequential PC and an older pending target.
    assign issue_addr    = br_valid ? br_target : pc_q;
    assign redir_any     = br_valid || pend_q;
    assign redirect_addr = br_valid ? br_target : tgt_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        en_ir_d    = 1'b0;
        pend_d     = pend_q;
        tgt_d      = tgt_q;

        unique case (state_q)
            S_IDLE: begin
                pc_d       = issue_addr;
                mem_addr_d = issue_addr;
                mem_rd_d   = 1'b1;
                state_d    = S_FETCH;
            end

            S_FETCH: begin
                mem_rd_d = 1'b1;
                if (mem_ack) begin
                    mem_rd_d = 1'b0;
                    if (redir_any) begin
                        // Word belongs to the abandoned path: drop it and refetch from the target.
                        pc_d    = redirect_addr;
                        pend_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        instr_d = mem_rdata;
                        en_ir_d = 1'b1;
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_HOLD;
                    end
                end else if (timeout) begin
                    mem_rd_d = 1'b0;
                    pc_d     = redir_any ? redirect_addr : pc_q;
                    pend_d   = 1'b0;
                    state_d  = S_IDLE;
                end else if (br_valid) begin
                    pend_d = 1'b1;
                    tgt_d  = br_target;
                end
            end

            S_HOLD: begin
                mem_rd_d = 1'b0;
                pc_d     = issue_addr;
                if (next_req) begin
                    mem_addr_d = issue_addr;
                    mem_rd_d   = 1'b1;
                    state_d    = S_FETCH;
                end
            end

            default: begin
                mem_rd_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            instr_q    <= 16'h0000;
            en_ir_q    <= 1'b0;
            pend_q     <= 1'b0;
            tgt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            en_ir_q    <= en_ir_d;
            pend_q     <= pend_d;
            tgt_q      <= tgt_d;
        end
    end

`ifdef IFETCH_TIMEOUT_EN
    always_comb begin
        cnt_d = 8'd0;
        err_d = err_q;
        if ((state_q == S_FETCH) && !mem_ack && !timeout) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign instr    = instr_q;
    assign en_ir    = en_ir_q;
    assign pc       = pc_q;

endmodule
